// File: rtl/dram_sched.sv
// In-order DRAM request scheduler: queues requests, decodes bank group/bank/row/column,
// tracks open rows per bank and hands one classified command at a time to the sequencer.
package dram_sched_pkg;
  typedef enum logic [1:0] {
    NULL  = 2'd0,
    HIT   = 2'd1,
    MISS  = 2'd2,
    EMPTY = 2'd3
  } dram_policy_t;
endpackage

module dram_sched
  import dram_sched_pkg::*;
#(
  parameter int unsigned QDEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [32:0]               req_addr,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output dram_policy_t              cmd_policy,
  output logic [1:0]                cmd_op,
  output logic [1:0]                cmd_bg,
  output logic [1:0]                cmd_bank,
  output logic [14:0]               cmd_row,
  output logic [10:0]               cmd_col,
  input  logic                      cmd_done,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [PW:0] C_DEPTH = (PW + 1)'(QDEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;
  localparam logic [1:0] S_WAIT     = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  // Only addr[32:3] is meaningful, so the low three bits are not stored.
  logic [29:0]   r_fifo_addr [QDEPTH];
  logic [1:0]    r_fifo_op   [QDEPTH];

  logic [15:0]   r_open;
  logic [14:0]   r_row [16];

  dram_policy_t  r_cmd_policy;
  logic [1:0]    r_cmd_op;
  logic [1:0]    r_cmd_bg;
  logic [1:0]    r_cmd_bank;
  logic [14:0]   r_cmd_row;
  logic [10:0]   r_cmd_col;

  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_req_op;
  logic [29:0]   w_head;
  logic [1:0]    w_head_op;
  logic [14:0]   w_row;
  logic [10:0]   w_col;
  logic [1:0]    w_bg;
  logic [1:0]    w_bank;
  logic [3:0]    w_idx;
  logic [3:0]    w_cmd_idx;
  dram_policy_t  w_policy;
  logic          w_unused_addr_lsb;

  assign req_ready = (r_count < C_DEPTH);
  assign q_count   = r_count;
  assign cmd_valid = (r_state == S_ISSUE);

  assign cmd_policy = r_cmd_policy;
  assign cmd_op     = r_cmd_op;
  assign cmd_bg     = r_cmd_bg;
  assign cmd_bank   = r_cmd_bank;
  assign cmd_row    = r_cmd_row;
  assign cmd_col    = r_cmd_col;

  assign w_push            = req_valid && req_ready;
  assign w_pop             = (r_state == S_ISSUE) && cmd_ready;
  assign w_req_op          = (req_op == 2'd3) ? 2'd0 : req_op;
  assign w_unused_addr_lsb = ^req_addr[2:0];

  // Head decode; bit positions are req_addr positions shifted down by 3.
  assign w_head    = r_fifo_addr[r_rd_ptr];
  assign w_head_op = r_fifo_op[r_rd_ptr];
  assign w_row     = w_head[29:15];
  assign w_col     = {w_head[14:7], w_head[2:0]};
  assign w_bank    = w_head[6:5];
  assign w_bg      = w_head[4:3];
  assign w_idx     = {w_bg, w_bank};
  assign w_cmd_idx = {r_cmd_bg, r_cmd_bank};

  always_comb begin
    w_policy = EMPTY;
    if (r_open[w_idx]) begin
      w_policy = (r_row[w_idx] == w_row) ? HIT : MISS;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= req_addr[32:3];
      r_fifo_op[r_wr_ptr]   <= w_req_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_open       <= '0;
      r_cmd_policy <= NULL;
      r_cmd_op     <= '0;
      r_cmd_bg     <= '0;
      r_cmd_bank   <= '0;
      r_cmd_row    <= '0;
      r_cmd_col    <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        r_row[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          r_cmd_policy <= w_policy;
          r_cmd_op     <= w_head_op;
          r_cmd_bg     <= w_bg;
          r_cmd_bank   <= w_bank;
          r_cmd_row    <= w_row;
          r_cmd_col    <= w_col;
          r_state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            r_open[w_cmd_idx] <= 1'b1;
            r_row[w_cmd_idx]  <= r_cmd_row;
            r_state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_sched.sv
// Scoreboard bench for dram_sched: a reference model predicts each command at request
// acceptance; a monitor pops and compares on every issue handshake.
module tb_dram_sched;
  import dram_sched_pkg::*;

  typedef struct packed {
    dram_policy_t pol;
    logic [1:0]   op;
    logic [1:0]   bg;
    logic [1:0]   bank;
    logic [14:0]  row;
    logic [10:0]  col;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [32:0]  req_addr;
  logic         cmd_valid;
  logic         cmd_ready;
  dram_policy_t cmd_policy;
  logic [1:0]   cmd_op;
  logic [1:0]   cmd_bg;
  logic [1:0]   cmd_bank;
  logic [14:0]  cmd_row;
  logic [10:0]  cmd_col;
  logic         cmd_done;
  logic [4:0]   q_count;

  int n_cmp;
  int n_fail;
  exp_t exp_q[$];
  bit   m_open [16];
  int   m_row  [16];

  // Sequencer behaviour: 0 = never ready, 1 = always ready, quick done,
  // 2 = random ready and done delay, 3 = always ready, done withheld.
  int seq_mode;
  int spur_req;
  int spur_ack;

  dram_sched #(.QDEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_policy (cmd_policy),
    .cmd_op     (cmd_op),
    .cmd_bg     (cmd_bg),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_done   (cmd_done),
    .q_count    (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
  endfunction

  // Open-page model: classify against the row left by earlier requests, then open it.
  function automatic exp_t model_accept(input logic [1:0] op, input logic [32:0] addr);
    exp_t e;
    longint unsigned a;
    int idx;
    a      = addr;
    e.op   = (op == 2'd3) ? 2'd0 : op;
    e.row  = 15'(a / 262144);
    e.col  = 11'(((a / 1024) % 256) * 8 + (a / 8) % 8);
    e.bank = 2'((a / 256) % 4);
    e.bg   = 2'((a / 64) % 4);
    idx    = e.bg * 4 + e.bank;
    if (!m_open[idx])               e.pol = EMPTY;
    else if (m_row[idx] == e.row)   e.pol = HIT;
    else                            e.pol = MISS;
    m_open[idx] = 1'b1;
    m_row[idx]  = e.row;
    return e;
  endfunction

  // Called just after a posedge; returns just after the acceptance edge.
  task automatic try_send(input logic [1:0] op, input logic [32:0] addr, input int limit,
                          output bit accepted);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    accepted  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (req_ready && !reset) begin
        accepted = 1'b1;
        exp_q.push_back(model_accept(op, addr));
      end
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [32:0] addr);
    bit acc;
    try_send(op, addr, 5000, acc);
    chk("req_accept", acc, 1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    exp_q.delete();
    model_clear();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || q_count != 0 || cmd_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < 5000), 1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] rand_addr();
    logic [14:0] row;
    logic [7:0]  ch;
    logic [1:0]  bk;
    logic [1:0]  bg;
    logic [2:0]  cl;
    logic [2:0]  lo;
    row = 15'($urandom_range(0, 3));
    ch  = 8'($urandom_range(0, 255));
    bk  = 2'($urandom_range(0, 3));
    bg  = 2'($urandom_range(0, 3));
    cl  = 3'($urandom_range(0, 7));
    lo  = 3'($urandom_range(0, 7));
    return {row, ch, bk, bg, cl, lo};
  endfunction

  // Sequencer stand-in: drives cmd_ready and cmd_done 2 time units after each posedge.
  initial begin
    int cnt;
    bit hs;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    spur_ack  = 0;
    cnt       = -1;
    forever begin
      @(negedge clk);
      hs = cmd_valid && cmd_ready && !reset;
      @(posedge clk);
      #2;
      cmd_done = 1'b0;
      if (hs) begin
        case (seq_mode)
          2:       cnt = $urandom_range(0, 3);
          3:       cnt = 1000000;
          default: cnt = 1;
        endcase
      end
      if (reset) cnt = -1;
      if (cnt == 0) begin
        cmd_done = 1'b1;
        cnt      = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (spur_req != spur_ack) begin
        cmd_done = 1'b1;
        spur_ack++;
      end
      case (seq_mode)
        0:       cmd_ready = 1'b0;
        1, 3:    cmd_ready = 1'b1;
        default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every issue handshake must match the oldest predicted command.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_issue: got row %0h col %0h, required no issue", cmd_row, cmd_col);
        end else begin
          e = exp_q.pop_front();
          chk("issue_policy", cmd_policy, e.pol);
          chk("issue_fields", {cmd_policy, cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col}, e);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [32:0] a;
    n_cmp     = 0;
    n_fail    = 0;
    seq_mode  = 1;
    spur_req  = 0;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    model_clear();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_policy", cmd_policy, NULL);
    chk("rst_cmd_fields", {cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col}, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk);
    #1;

    // First request: latency and the decoded fields against fixed values.
    send(2'd0, 33'h0_0004_0000);
    @(negedge clk);
    chk("lat_q_count_n", q_count, 1);
    chk("lat_valid_n", cmd_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_valid_n1", cmd_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_valid_n2", cmd_valid, 1);
    chk("first_policy", cmd_policy, EMPTY);
    chk("first_bg_bank", {cmd_bg, cmd_bank}, 0);
    chk("first_row", cmd_row, 1);
    chk("first_col", cmd_col, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pop_valid", cmd_valid, 0);
    chk("pop_q_count", q_count, 0);
    @(posedge clk);
    #1;
    drain();

    send(2'd0, 33'h0_0004_0400);
    send(2'd0, 33'h0_0008_0000);
    send(2'd0, 33'h0_0000_0100);
    send(2'd0, 33'h0_0008_0040);
    send(2'd1, 33'h0_0008_0000);
    send(2'd3, 33'h0_0004_0000);
    drain();

    // Full queue with the sequencer stalled.
    seq_mode = 0;
    for (int i = 0; i < 16; i++) begin
      a = rand_addr();
      send(2'($urandom_range(0, 3)), a);
    end
    @(negedge clk);
    chk("full_q_count", q_count, 16);
    chk("full_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    try_send(2'd0, 33'h0_0010_0000, 3, acc);
    chk("full_reject", acc, 0);
    @(negedge clk);
    chk("full_q_count_after", q_count, 16);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) spur_req++;
      @(negedge clk);
      chk("hold_valid", cmd_valid, 1);
      chk("hold_fields", {cmd_policy, cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col}, exp_q[0]);
      @(posedge clk);
      #1;
    end
    seq_mode = 1;
    @(negedge clk);
    chk("popedge_req_ready", req_ready, 0);
    chk("popedge_q_count", q_count, 16);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reopen_q_count", q_count, 15);
    chk("reopen_req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    drain();

    // Stray done while idle must not start anything.
    spur_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_done_valid", cmd_valid, 0);
      chk("idle_done_q_count", q_count, 0);
      @(posedge clk);
      #1;
    end

    // Reset while waiting for done with three requests queued.
    seq_mode = 3;
    send(2'd0, 33'h0_000C_0000);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    send(2'd0, 33'h0_0004_0000);
    send(2'd1, 33'h0_0000_0100);
    send(2'd2, 33'h0_0008_0040);
    @(negedge clk);
    chk("wait_q_count", q_count, 3);
    chk("wait_valid", cmd_valid, 0);
    @(posedge clk);
    #1;
    do_reset(1);
    @(negedge clk);
    chk("midrst_q_count", q_count, 0);
    chk("midrst_valid", cmd_valid, 0);
    chk("midrst_policy", cmd_policy, NULL);
    chk("midrst_req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    seq_mode = 1;
    send(2'd0, 33'h0_000C_0000);
    send(2'd0, 33'h0_0004_0000);
    drain();

    // Randomised traffic with a random sequencer and one reset in flight.
    seq_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if (i == 100) do_reset(2);
      a = rand_addr();
      send(2'($urandom_range(0, 3)), a);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
